// File: rtl/data_sram_responder.sv
// -----------------------------------------------------------------------------
// data_sram_responder
//
// Responder end of the data SRAM interface driven by the EX stage. It holds a
// word-organised data memory with per-byte write enables and a registered
// (synchronous) read port. It can optionally insert wait states, and while an
// access is outstanding it raises a stall request that freezes the pipeline.
//
// Parameters
//   ADDR_W       word-address width; depth = 2**ADDR_W words of 32 bits
//   WAIT_CYCLES  cycles spent in WAIT per access (0 = zero-wait, pipelined)
//
// Ports
//   clk                in   clock, all state updates on posedge
//   rst                in   synchronous active-high reset
//   data_sram_en       in   access request valid this cycle
//   data_sram_wen      in   [3:0] byte write enables, 4'b0000 = read
//   data_sram_addr     in   [31:0] byte address, word index = addr[ADDR_W+1:2]
//   data_sram_wdata    in   [31:0] write data, byte lanes already positioned
//   data_sram_rdata    out  [31:0] registered read data
//   rdata_valid        out  one-cycle pulse when rdata carries a new result
//   stallreq_for_mem   out  pipeline stall request
//   data_sram_addr_err out  (only with DSRAM_ALIGN_CHK_EN) one-cycle pulse
//                           flagging a suppressed misaligned write
//
// Optional feature macro: DSRAM_ALIGN_CHK_EN
//   Defined: misaligned writes (word write with addr[1:0]!=0, halfword write
//   with addr[0]!=0) are dropped and reported on data_sram_addr_err.
//   Undefined: no error port, addr[1:0] ignored, every write is performed.
// -----------------------------------------------------------------------------
module data_sram_responder #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
`ifdef DSRAM_ALIGN_CHK_EN
    output logic        data_sram_addr_err,
`endif
    output logic [31:0] data_sram_rdata,
    output logic        rdata_valid,
    output logic        stallreq_for_mem
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Request as presented on the inputs this cycle.
    logic [ADDR_W-1:0] req_idx;
    logic              req_misalign;

    assign req_idx = data_sram_addr[ADDR_W+1:2];

`ifdef DSRAM_ALIGN_CHK_EN
    always_comb begin
        req_misalign = 1'b0;
        case (data_sram_wen)
            4'b1111:          req_misalign = (data_sram_addr[1:0] != 2'b00);
            4'b0011, 4'b1100: req_misalign = data_sram_addr[0];
            default:          req_misalign = 1'b0;
        endcase
    end
`else
    assign req_misalign = 1'b0;
`endif

    // Address bits outside the word index are intentionally ignored (wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    // The access that executes at the coming clock edge, whichever mode.
    logic              exec_fire;
    logic [3:0]        exec_wen;
    logic [ADDR_W-1:0] exec_idx;
    logic [31:0]       exec_wdata;
    logic              exec_misalign;

    generate
        if (WAIT_CYCLES == 0) begin : g_zero_wait
            // Zero-wait: every request executes at the end of its own cycle.
            assign exec_fire        = data_sram_en;
            assign exec_wen         = data_sram_wen;
            assign exec_idx         = req_idx;
            assign exec_wdata       = data_sram_wdata;
            assign exec_misalign    = req_misalign;
            assign stallreq_for_mem = 1'b0;
        end else begin : g_wait
            localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
            localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

            logic [1:0]        state_reg, state_next;
            logic [CNT_W-1:0]  cnt_reg, cnt_next;
            logic [3:0]        lat_wen_reg, lat_wen_next;
            logic [ADDR_W-1:0] lat_idx_reg, lat_idx_next;
            logic [31:0]       lat_wdata_reg, lat_wdata_next;
            logic              lat_misalign_reg, lat_misalign_next;

            always_comb begin
                state_next        = state_reg;
                cnt_next          = cnt_reg;
                lat_wen_next      = lat_wen_reg;
                lat_idx_next      = lat_idx_reg;
                lat_wdata_next    = lat_wdata_reg;
                lat_misalign_next = lat_misalign_reg;
                case (state_reg)
                    ST_IDLE: begin
                        if (data_sram_en) begin
                            lat_wen_next      = data_sram_wen;
                            lat_idx_next      = req_idx;
                            lat_wdata_next    = data_sram_wdata;
                            lat_misalign_next = req_misalign;
                            cnt_next          = CNT_INIT;
                            state_next        = ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (cnt_reg == '0) begin
                            state_next = ST_DONE;
                        end else begin
                            cnt_next = cnt_reg - 1'b1;
                        end
                    end
                    // DONE: en still shows the request just served; drop it.
                    ST_DONE: state_next = ST_IDLE;
                    default: state_next = ST_IDLE;
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg        <= ST_IDLE;
                    cnt_reg          <= '0;
                    lat_wen_reg      <= '0;
                    lat_idx_reg      <= '0;
                    lat_wdata_reg    <= '0;
                    lat_misalign_reg <= 1'b0;
                end else begin
                    state_reg        <= state_next;
                    cnt_reg          <= cnt_next;
                    lat_wen_reg      <= lat_wen_next;
                    lat_idx_reg      <= lat_idx_next;
                    lat_wdata_reg    <= lat_wdata_next;
                    lat_misalign_reg <= lat_misalign_next;
                end
            end

            assign exec_fire     = (state_reg == ST_WAIT) && (cnt_reg == '0);
            assign exec_wen      = lat_wen_reg;
            assign exec_idx      = lat_idx_reg;
            assign exec_wdata    = lat_wdata_reg;
            assign exec_misalign = lat_misalign_reg;

            // Stall from the request cycle itself until the access executes.
            assign stallreq_for_mem = (state_reg == ST_IDLE) ? data_sram_en
                                                             : (state_reg == ST_WAIT);
        end
    endgenerate

    // Reset wins over an executing access so nothing is written during reset.
    logic do_write;
    logic do_read;

    assign do_write = !rst && exec_fire && (exec_wen != 4'b0000) && !exec_misalign;
    assign do_read  = !rst && exec_fire && (exec_wen == 4'b0000);

    // One byte-wide memory per lane so each lane maps onto a plain BRAM port.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH];
            logic [7:0] rdata_lane_reg;

            always_ff @(posedge clk) begin
                if (do_write && exec_wen[gi]) begin
                    mem_lane[exec_idx] <= exec_wdata[8*gi +: 8];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_lane_reg <= 8'h00;
                end else if (do_read) begin
                    rdata_lane_reg <= mem_lane[exec_idx];
                end
            end

            assign data_sram_rdata[8*gi +: 8] = rdata_lane_reg;
        end
    endgenerate

    logic rdata_valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_valid_reg <= 1'b0;
        end else begin
            rdata_valid_reg <= do_read;
        end
    end

    assign rdata_valid = rdata_valid_reg;

`ifdef DSRAM_ALIGN_CHK_EN
    logic addr_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_err_reg <= 1'b0;
        end else begin
            addr_err_reg <= exec_fire && exec_misalign;
        end
    end

    assign data_sram_addr_err = addr_err_reg;
`endif

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

    localparam int W3 = 3;

    logic clk;

    // Zero-wait instance
    logic        rst0, en0, valid0, stall0;
    logic [3:0]  wen0;
    logic [31:0] addr0, wdata0, rdata0;
    // Three-wait-state instance
    logic        rst3, en3, valid3, stall3;
    logic [3:0]  wen3;
    logic [31:0] addr3, wdata3, rdata3;
`ifdef DSRAM_ALIGN_CHK_EN
    logic        err0, err3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    data_sram_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) dut0 (
        .clk              (clk),
        .rst              (rst0),
        .data_sram_en     (en0),
        .data_sram_wen    (wen0),
        .data_sram_addr   (addr0),
        .data_sram_wdata  (wdata0),
`ifdef DSRAM_ALIGN_CHK_EN
        .data_sram_addr_err(err0),
`endif
        .data_sram_rdata  (rdata0),
        .rdata_valid      (valid0),
        .stallreq_for_mem (stall0)
    );

    data_sram_responder #(.ADDR_W(12), .WAIT_CYCLES(W3)) dut3 (
        .clk              (clk),
        .rst              (rst3),
        .data_sram_en     (en3),
        .data_sram_wen    (wen3),
        .data_sram_addr   (addr3),
        .data_sram_wdata  (wdata3),
`ifdef DSRAM_ALIGN_CHK_EN
        .data_sram_addr_err(err3),
`endif
        .data_sram_rdata  (rdata3),
        .rdata_valid      (valid3),
        .stallreq_for_mem (stall3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request to dut0 at the falling edge; it executes at the next rising edge.
    task automatic drive0(input logic e, input logic [3:0] w, input logic [31:0] a,
                          input logic [31:0] d);
        @(negedge clk);
        en0 = e; wen0 = w; addr0 = a; wdata0 = d;
    endtask

    // Full held-request transaction on dut3; returns outputs seen in the DONE cycle.
    task automatic req3(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic vld);
        @(negedge clk);
        en3 = 1'b1; wen3 = w; addr3 = a; wdata3 = d;
        repeat (W3 + 1) @(negedge clk);
        rd  = rdata3;
        vld = valid3;
        @(negedge clk);
        en3 = 1'b0;
        $display("dut3 txn wen=%b addr=%h wdata=%h -> rdata=%h valid=%b", w, a, d, rd, vld);
    endtask

    task automatic test_reset;
        rst0 = 1'b1; rst3 = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (rdata0 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata0 got %h want %h", rdata0, 32'h0); end
        n_checks++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid0 got %b want 0", valid0); end
        n_checks++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL reset_stall0 got %b want 0", stall0); end
        n_checks++; if (rdata3 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata3 got %h want %h", rdata3, 32'h0); end
        n_checks++; if (valid3 !== 1'b0) begin n_fail++; $display("FAIL reset_valid3 got %b want 0", valid3); end
        n_checks++; if (stall3 !== 1'b0) begin n_fail++; $display("FAIL reset_stall3 got %b want 0", stall3); end
`ifdef DSRAM_ALIGN_CHK_EN
        n_checks++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL reset_err0 got %b want 0", err0); end
`endif
        rst0 = 1'b0; rst3 = 1'b0;
        $display("reset: rdata0=%h valid0=%b stall0=%b rdata3=%h valid3=%b stall3=%b",
                 rdata0, valid0, stall0, rdata3, valid3, stall3);
    endtask

    task automatic test_basic;
        drive0(1'b1, 4'b1111, 32'h10, 32'hDEADBEEF);
        #1;
        n_checks++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL basic_stall_wr got %b want 0", stall0); end
        drive0(1'b1, 4'b0000, 32'h10, 32'h0);
        #1;
        n_checks++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL basic_wr_valid got %b want 0", valid0); end
        n_checks++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL basic_stall_rd got %b want 0", stall0); end
        drive0(1'b0, 4'b0000, 32'h0, 32'h0);
        n_checks++; if (rdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_rdata got %h want %h", rdata0, 32'hDEADBEEF); end
        n_checks++; if (valid0 !== 1'b1) begin n_fail++; $display("FAIL basic_rd_valid got %b want 1", valid0); end
        $display("basic: write 0x10=deadbeef then read -> rdata=%h valid=%b", rdata0, valid0);
        drive0(1'b0, 4'b0000, 32'h0, 32'h0);
        n_checks++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL basic_valid_pulse got %b want 0", valid0); end
        n_checks++; if (rdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_rdata_hold got %h want %h", rdata0, 32'hDEADBEEF); end
    endtask

    task automatic test_byte_lanes;
        drive0(1'b1, 4'b1111, 32'h20, 32'h11223344);
        drive0(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD);
        drive0(1'b1, 4'b0000, 32'h20, 32'h0);
        // Two writes have executed: rdata must still hold the last read result.
        n_checks++; if (rdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lanes_wr_keeps_rdata got %h want %h", rdata0, 32'hDEADBEEF); end
        n_checks++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL lanes_wr_valid got %b want 0", valid0); end
        drive0(1'b0, 4'b0000, 32'h0, 32'h0);
        n_checks++; if (rdata0 !== 32'h11BB33DD) begin n_fail++; $display("FAIL lanes_rdata got %h want %h", rdata0, 32'h11BB33DD); end
        n_checks++; if (valid0 !== 1'b1) begin n_fail++; $display("FAIL lanes_valid got %b want 1", valid0); end
        $display("byte_lanes: read 0x20 -> rdata=%h valid=%b", rdata0, valid0);
    endtask

    task automatic test_wrap;
        drive0(1'b1, 4'b1111, 32'h4000, 32'h5A5A5A5A);
        drive0(1'b1, 4'b0000, 32'h0000, 32'h0);
        drive0(1'b0, 4'b0000, 32'h0, 32'h0);
        n_checks++; if (rdata0 !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL wrap_rdata got %h want %h", rdata0, 32'h5A5A5A5A); end
        n_checks++; if (valid0 !== 1'b1) begin n_fail++; $display("FAIL wrap_valid got %b want 1", valid0); end
        $display("wrap: write 0x4000 read 0x0 -> rdata=%h valid=%b", rdata0, valid0);
    endtask

    task automatic test_wait_read;
        logic [31:0] rd;
        logic        vld;
        req3(4'b1111, 32'h30, 32'hCAFEF00D, rd, vld);
        n_checks++; if (vld !== 1'b0) begin n_fail++; $display("FAIL wait_wr_valid got %b want 0", vld); end
        req3(4'b1111, 32'h34, 32'h0BADF00D, rd, vld);
        // Cycle N: read presented and held.
        @(negedge clk);
        en3 = 1'b1; wen3 = 4'b0000; addr3 = 32'h30; wdata3 = 32'h0;
        #1;
        n_checks++; if (stall3 !== 1'b1) begin n_fail++; $display("FAIL wait_stall_N got %b want 1", stall3); end
        for (int k = 1; k <= W3; k++) begin
            @(negedge clk);
            n_checks++; if (stall3 !== 1'b1) begin n_fail++; $display("FAIL wait_stall_N+%0d got %b want 1", k, stall3); end
            n_checks++; if (valid3 !== 1'b0) begin n_fail++; $display("FAIL wait_valid_N+%0d got %b want 0", k, valid3); end
        end
        @(negedge clk); // N+4: DONE
        n_checks++; if (stall3 !== 1'b0) begin n_fail++; $display("FAIL wait_stall_done got %b want 0", stall3); end
        n_checks++; if (valid3 !== 1'b1) begin n_fail++; $display("FAIL wait_valid_done got %b want 1", valid3); end
        n_checks++; if (rdata3 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL wait_rdata_done got %h want %h", rdata3, 32'hCAFEF00D); end
        $display("wait_read: DONE rdata=%h valid=%b stall=%b", rdata3, valid3, stall3);
        @(negedge clk); // N+5: back in IDLE, held request must not have restarted
        en3 = 1'b0;
        #1;
        n_checks++; if (stall3 !== 1'b0) begin n_fail++; $display("FAIL wait_idle_stall got %b want 0", stall3); end
        n_checks++; if (valid3 !== 1'b0) begin n_fail++; $display("FAIL wait_valid_once got %b want 0", valid3); end
        en3 = 1'b1; wen3 = 4'b0000; addr3 = 32'h34;
        #1;
        n_checks++; if (stall3 !== 1'b1) begin n_fail++; $display("FAIL wait_accept_N+5 got %b want 1", stall3); end
        repeat (W3 + 1) @(negedge clk);
        n_checks++; if (valid3 !== 1'b1) begin n_fail++; $display("FAIL wait_second_valid got %b want 1", valid3); end
        n_checks++; if (rdata3 !== 32'h0BADF00D) begin n_fail++; $display("FAIL wait_second_rdata got %h want %h", rdata3, 32'h0BADF00D); end
        $display("wait_read: second read 0x34 -> rdata=%h valid=%b", rdata3, valid3);
        @(negedge clk);
        en3 = 1'b0;
    endtask

    task automatic test_wait_reset;
        logic [31:0] rd;
        logic        vld;
        req3(4'b1111, 32'h40, 32'h12345678, rd, vld);
        @(negedge clk); // cycle N: write request
        en3 = 1'b1; wen3 = 4'b1111; addr3 = 32'h40; wdata3 = 32'hFFFF0000;
        @(negedge clk); // N+1: WAIT cnt=2
        @(negedge clk); // N+2: WAIT cnt=1, reset hits at the end of this cycle
        rst3 = 1'b1; en3 = 1'b0;
        @(negedge clk);
        n_checks++; if (stall3 !== 1'b0) begin n_fail++; $display("FAIL rst_wait_stall got %b want 0", stall3); end
        n_checks++; if (rdata3 !== 32'h0) begin n_fail++; $display("FAIL rst_wait_rdata got %h want %h", rdata3, 32'h0); end
        n_checks++; if (valid3 !== 1'b0) begin n_fail++; $display("FAIL rst_wait_valid got %b want 0", valid3); end
        rst3 = 1'b0;
        req3(4'b0000, 32'h40, 32'h0, rd, vld);
        n_checks++; if (vld !== 1'b1) begin n_fail++; $display("FAIL rst_wait_rb_valid got %b want 1", vld); end
        n_checks++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL rst_wait_mem got %h want %h", rd, 32'h12345678); end
    endtask

`ifdef DSRAM_ALIGN_CHK_EN
    task automatic test_align;
        drive0(1'b1, 4'b1111, 32'h22, 32'hFFFFFFFF);
        drive0(1'b1, 4'b0000, 32'h22, 32'h0);
        n_checks++; if (err0 !== 1'b1) begin n_fail++; $display("FAIL align_err got %b want 1", err0); end
        drive0(1'b0, 4'b0000, 32'h0, 32'h0);
        n_checks++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL align_err_read got %b want 0", err0); end
        n_checks++; if (rdata0 !== 32'h11BB33DD) begin n_fail++; $display("FAIL align_mem got %h want %h", rdata0, 32'h11BB33DD); end
        n_checks++; if (valid0 !== 1'b1) begin n_fail++; $display("FAIL align_valid got %b want 1", valid0); end
        $display("align: misaligned write 0x22 suppressed, readback=%h err=%b", rdata0, err0);
    endtask
`endif

    initial begin
        rst0 = 1'b1; en0 = 1'b0; wen0 = 4'b0; addr0 = 32'h0; wdata0 = 32'h0;
        rst3 = 1'b1; en3 = 1'b0; wen3 = 4'b0; addr3 = 32'h0; wdata3 = 32'h0;
        test_reset();
        test_basic();
        test_byte_lanes();
        test_wrap();
        test_wait_read();
        test_wait_reset();
`ifdef DSRAM_ALIGN_CHK_EN
        test_align();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
